user_port_arbiter: RTL and testbench

Round-robin arbiter that lets NUM_REQ user-side producer streams share one leaf output port of the leaf interface. It sits on the clk_user side between user operators and a single din_leaf_user2interface / vld / ack channel. Each grant covers a burst of up to BURST_LEN words, and the merged stream passes through one registered output stage. A source index is carried alongside each word so downstream packetisation can tag it.

---
 rtl/user_arb_pkg.sv | 18 +
 rtl/user_port_arbiter_rr_pick.sv | 31 +++
 rtl/user_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_user_port_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_arb_pkg.sv
// Shared types and helpers for the user-side port arbiter.
// Holds the arbitration state encoding, the statistics counter width
// and the round-robin pointer advance rule.
package user_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int STAT_BITS = 16;

    // Pointer moves to the requester just after the one released, wrapping at num_req.
    function automatic int rr_next(input int grant, input int num_req);
        return (grant + 1 >= num_req) ? 0 : grant + 1;
    endfunction

endpackage

// File: rtl/user_port_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or after rr_ptr, wrapping upward.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
    parameter int NUM_REQ  = 2,
    parameter int REQ_BITS = 4
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [REQ_BITS-1:0] rr_ptr,
    output logic                found,
    output logic [REQ_BITS-1:0] index
);

    logic [NUM_REQ-1:0] req_rot;

    // Rotate so that bit 0 is the requester at rr_ptr, bit i the one i places above it.
    assign req_rot = NUM_REQ'({req, req} >> rr_ptr);

    // Lowest set bit of the rotated vector wins; walking downward lets it overwrite the rest.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                found = 1'b1;
                index = REQ_BITS'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/user_port_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ user streams onto one port; ARB_STATS_EN adds stat_words.
// Latency: one cycle from accepted requester word to dout/vld_out; one bubble cycle per grant.
// Backpressure: ack_req to the granted requester only while the output stage is empty or draining.
module user_port_arbiter
    import user_arb_pkg::*;
#(
    parameter int PAYLOAD_BITS = 32,
    parameter int NUM_REQ      = 2,
    parameter int REQ_BITS     = 4,
    parameter int BURST_LEN    = 16
) (
    input  logic                            clk_user,
    input  logic                            reset,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
    input  logic [NUM_REQ-1:0]              vld_req,
    output logic [NUM_REQ-1:0]              ack_req,
    output logic [PAYLOAD_BITS-1:0]         dout,
    output logic [REQ_BITS-1:0]             dout_src,
    output logic                            vld_out,
    input  logic                            ack_in
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_BITS-1:0]    stat_words
`endif
);

    localparam int CNT_BITS = $clog2(BURST_LEN + 1);

    arb_state_t              state;
    arb_state_t              state_nxt;
    logic [REQ_BITS-1:0]     grant;
    logic [REQ_BITS-1:0]     rr_ptr;
    logic [REQ_BITS-1:0]     pick_idx;
    logic                    pick_found;
    logic [CNT_BITS-1:0]     burst_cnt;
    logic [PAYLOAD_BITS-1:0] out_data;
    logic [PAYLOAD_BITS-1:0] grant_dat;
    logic [REQ_BITS-1:0]     out_src;
    logic                    vld_out_r;
    logic                    out_free;
    logic                    grant_vld;
    logic                    accept;
    logic                    grant_done;
    logic [NUM_REQ-1:0]      grant_oh;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .REQ_BITS (REQ_BITS)
    ) u_pick (
        .req    (vld_req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .index  (pick_idx)
    );

    assign grant_oh  = NUM_REQ'(1) << grant;
    assign grant_vld = |(vld_req & grant_oh);
    // Stage can take a word when empty or when its current word leaves this cycle.
    assign out_free  = !vld_out_r || ack_in;

    // Select the granted requester's word from the flat input bus.
    always_comb begin
        grant_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == REQ_BITS'(i)) begin
                grant_dat = din_req[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    // Next state, requester acks and grant release.
    always_comb begin
        state_nxt  = state;
        ack_req    = '0;
        accept     = 1'b0;
        grant_done = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                ack_req    = out_free ? grant_oh : '0;
                accept     = grant_vld && out_free;
                grant_done = !grant_vld ||
                             (accept && burst_cnt == CNT_BITS'(BURST_LEN - 1));
                if (grant_done) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant capture, burst length tracking and round-robin pointer advance.
    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            grant     <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
        end else if (state == ARB_IDLE) begin
            if (pick_found) begin
                grant     <= pick_idx;
                burst_cnt <= '0;
            end
        end else begin
            if (accept) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (grant_done) begin
                rr_ptr <= REQ_BITS'(rr_next(int'(grant), NUM_REQ));
            end
        end
    end

    // Registered output stage: load on accept, empty when drained without a refill.
    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_src   <= '0;
            vld_out_r <= 1'b0;
        end else if (accept) begin
            out_data  <= grant_dat;
            out_src   <= grant;
            vld_out_r <= 1'b1;
        end else if (ack_in) begin
            vld_out_r <= 1'b0;
        end
    end

    assign dout     = out_data;
    assign dout_src = out_src;
    assign vld_out  = vld_out_r;

`ifdef ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_BITS-1:0] stat_cnt;

    // One saturating accepted-word counter per requester, cleared only by reset.
    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            stat_cnt <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant == REQ_BITS'(i) && stat_cnt[i] != {STAT_BITS{1'b1}}) begin
                    stat_cnt[i] <= stat_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign stat_words = stat_cnt;
`endif

endmodule

// File: tb/tb_user_port_arbiter.sv
// Self-checking bench for user_port_arbiter with a cycle-level reference model.
// Latency: model predicts outputs each cycle; directed scenarios add explicit checks.
// Backpressure: ack_in driven directed and randomly.
module tb_user_port_arbiter;

    localparam int PB = 32;
    localparam int N  = 3;
    localparam int RB = 4;
    localparam int BL = 4;

    logic            clk_user = 1'b0;
    logic            reset    = 1'b0;
    logic [N*PB-1:0] din_req  = '0;
    logic [N-1:0]    vld_req  = '0;
    logic [N-1:0]    ack_req;
    logic [PB-1:0]   dout;
    logic [RB-1:0]   dout_src;
    logic            vld_out;
    logic            ack_in   = 1'b0;

`ifdef ARB_STATS_EN
    logic [N*16-1:0] stat_words;
    logic [2*PB-1:0] s_din    = 64'h1234_5678_0000_0000;
    logic [1:0]      s_vld    = '0;
    logic [1:0]      s_ack_req;
    logic [PB-1:0]   s_dout;
    logic [RB-1:0]   s_src;
    logic            s_vout;
    logic            s_ack_in = 1'b0;
    logic [31:0]     s_stat;
`endif

    always #5 clk_user = ~clk_user;

    user_port_arbiter #(
        .PAYLOAD_BITS (PB),
        .NUM_REQ      (N),
        .REQ_BITS     (RB),
        .BURST_LEN    (BL)
    ) dut (
        .clk_user (clk_user),
        .reset    (reset),
        .din_req  (din_req),
        .vld_req  (vld_req),
        .ack_req  (ack_req),
        .dout     (dout),
        .dout_src (dout_src),
        .vld_out  (vld_out),
        .ack_in   (ack_in)
`ifdef ARB_STATS_EN
        ,
        .stat_words (stat_words)
`endif
    );

`ifdef ARB_STATS_EN
    user_port_arbiter #(
        .PAYLOAD_BITS (PB),
        .NUM_REQ      (2),
        .REQ_BITS     (RB),
        .BURST_LEN    (256)
    ) u_stats (
        .clk_user   (clk_user),
        .reset      (reset),
        .din_req    (s_din),
        .vld_req    (s_vld),
        .ack_req    (s_ack_req),
        .dout       (s_dout),
        .dout_src   (s_src),
        .vld_out    (s_vout),
        .ack_in     (s_ack_in),
        .stat_words (s_stat)
    );
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // requester sources: words left to send, word currently offered
    int            rem [N];
    logic [PB-1:0] nxt [N];
    bit            seq_mode;

    // reference model: ownership of the port, words taken in this burst, output stage
    bit            m_busy;
    bit            m_vout;
    int            m_owner;
    int            m_taken;
    int            m_ptr;
    int            m_src;
    logic [PB-1:0] m_dat;
    int            m_cnt [N];

    // words seen leaving the output stage
    logic [PB-1:0] wq_dat[$];
    int            wq_src[$];
    int            wq_cyc[$];

    task automatic model_reset();
        m_busy = 0; m_vout = 0; m_owner = 0; m_taken = 0; m_ptr = 0;
        m_src = 0; m_dat = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic clear_q();
        wq_dat.delete(); wq_src.delete(); wq_cyc.delete();
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            vld_req[i] = (rem[i] > 0);
            din_req[i*PB +: PB] = nxt[i];
        end
    endtask

    // Called at posedge+1: hold reset for two edges with all sources idle.
    task automatic hold_reset();
        reset = 1'b0;
        ack_in = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        drive_inputs();
        model_reset();
        repeat (2) @(posedge clk_user);
        #1 reset = 1'b1;
    endtask

    // One clock cycle: drive, compare against model at negedge, advance model and sources.
    task automatic tick();
        logic [N-1:0]  exp_ack;
        logic [N-1:0]  acked;
        logic [RB-1:0] exp_src;
        bit            acc;
        int            s;
        bit            fnd;
        drive_inputs();
        @(negedge clk_user);
        exp_ack = '0;
        if (m_busy && (!m_vout || ack_in)) exp_ack = N'(1) << m_owner;
        exp_src = m_src[RB-1:0];
        checks++;
        if (ack_req !== exp_ack) begin
            failures++;
            $display("FAIL ack_req cyc=%0d got=%b exp=%b", cyc, ack_req, exp_ack);
        end
        checks++;
        if (vld_out !== m_vout) begin
            failures++;
            $display("FAIL vld_out cyc=%0d got=%b exp=%b", cyc, vld_out, m_vout);
        end
        checks++;
        if (dout !== m_dat) begin
            failures++;
            $display("FAIL dout cyc=%0d got=%h exp=%h", cyc, dout, m_dat);
        end
        checks++;
        if (dout_src !== exp_src) begin
            failures++;
            $display("FAIL dout_src cyc=%0d got=%0d exp=%0d", cyc, dout_src, exp_src);
        end
        if (vld_out && ack_in) begin
            wq_dat.push_back(dout); wq_src.push_back(int'(dout_src)); wq_cyc.push_back(cyc);
        end
        acked = vld_req & ack_req;
        // model advance from this cycle's inputs
        if (!m_busy) begin
            fnd = 0;
            for (int k = 0; k < N; k++) begin
                s = (m_ptr + k) % N;
                if (!fnd && vld_req[s]) begin
                    fnd = 1; m_owner = s;
                end
            end
            if (fnd) begin
                m_busy = 1; m_taken = 0;
            end
            if (ack_in) m_vout = 0;
        end else begin
            acc = vld_req[m_owner] && (!m_vout || ack_in);
            if (acc) begin
                m_dat = nxt[m_owner]; m_src = m_owner; m_vout = 1;
                m_taken++; m_cnt[m_owner]++;
            end else if (ack_in) begin
                m_vout = 0;
            end
            if (!vld_req[m_owner] || (acc && m_taken == BL)) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
        @(posedge clk_user);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acked[i]) begin
                rem[i]--;
                nxt[i] = seq_mode ? nxt[i] + 1 : $urandom;
            end
        end
        cyc++;
    endtask

    task automatic test_reset();
        hold_reset();
        reset = 1'b0;
        @(negedge clk_user);
        checks++;
        if (vld_out !== 1'b0) begin failures++; $display("FAIL reset_vld_out got=%b exp=0", vld_out); end
        checks++;
        if (dout !== '0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
        checks++;
        if (dout_src !== '0) begin failures++; $display("FAIL reset_dout_src got=%0d exp=0", dout_src); end
        checks++;
        if (ack_req !== '0) begin failures++; $display("FAIL reset_ack_req got=%b exp=0", ack_req); end
        @(posedge clk_user);
        #1 reset = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_single();
        int t0;
        hold_reset();
        seq_mode = 1; ack_in = 1'b1;
        rem[0] = 4; nxt[0] = 32'h11;
        clear_q();
        t0 = cyc;
        repeat (10) tick();
        checks++;
        if (wq_dat.size() != 4) begin
            failures++; $display("FAIL single_count got=%0d exp=4", wq_dat.size());
        end
        for (int k = 0; k < 4 && k < wq_dat.size(); k++) begin
            checks++;
            if (wq_dat[k] !== PB'(32'h11 + k) || wq_src[k] != 0 || wq_cyc[k] != t0 + 2 + k) begin
                failures++;
                $display("FAIL single_word%0d got=%h/src%0d/cyc%0d exp=%h/src0/cyc%0d",
                         k, wq_dat[k], wq_src[k], wq_cyc[k], 32'h11 + k, t0 + 2 + k);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int cnt [2];
        int es;
        hold_reset();
        seq_mode = 1; ack_in = 1'b1;
        rem[0] = 100; nxt[0] = 32'h100;
        rem[1] = 100; nxt[1] = 32'h200;
        clear_q();
        t0 = cyc;
        repeat (20) tick();
        cnt[0] = 0; cnt[1] = 0;
        checks++;
        if (wq_dat.size() < 12) begin
            failures++; $display("FAIL b2b_count got=%0d exp>=12", wq_dat.size());
        end
        for (int k = 0; k < 12 && k < wq_dat.size(); k++) begin
            es = (k / 4) % 2;
            checks++;
            if (wq_src[k] != es || wq_dat[k] !== PB'((es ? 32'h200 : 32'h100) + cnt[es]) ||
                wq_cyc[k] != t0 + 2 + k + k / 4) begin
                failures++;
                $display("FAIL b2b_word%0d got=src%0d/%h/cyc%0d exp=src%0d/cyc%0d",
                         k, wq_src[k], wq_dat[k], wq_cyc[k], es, t0 + 2 + k + k / 4);
            end
            cnt[es]++;
        end
    endtask

    task automatic test_backpressure();
        hold_reset();
        seq_mode = 1; ack_in = 1'b0;
        rem[0] = 10; nxt[0] = 32'hA5;
        repeat (2) tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (dout !== 32'hA5 || vld_out !== 1'b1 || ack_req !== '0) begin
                failures++;
                $display("FAIL stall%0d got=dout %h vld %b ack %b exp=dout a5 vld 1 ack 000",
                         k, dout, vld_out, ack_req);
            end
        end
        ack_in = 1'b1;
        tick();
        checks++;
        if (dout !== 32'hA6 || vld_out !== 1'b1) begin
            failures++;
            $display("FAIL stall_resume got=%h/%b exp=a6/1", dout, vld_out);
        end
        repeat (6) tick();
    endtask

    task automatic test_fairness();
        hold_reset();
        seq_mode = 1; ack_in = 1'b1;
        rem[1] = 1; nxt[1] = 32'h300;
        repeat (3) tick();
        rem[0] = 8; nxt[0] = 32'h400;
        rem[1] = 8;
        clear_q();
        repeat (14) tick();
        checks++;
        if (wq_src.size() < 5) begin
            failures++; $display("FAIL wrap_count got=%0d exp>=5", wq_src.size());
        end else begin
            checks++;
            if (wq_src[0] != 0) begin
                failures++; $display("FAIL wrap_first got=src%0d exp=src0", wq_src[0]);
            end
            checks++;
            if (wq_src[4] != 1) begin
                failures++; $display("FAIL wrap_next got=src%0d exp=src1", wq_src[4]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        hold_reset();
        seq_mode = 1; ack_in = 1'b1;
        rem[1] = 50; nxt[1] = 32'h500;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        checks++;
        if (vld_out !== 1'b0 || ack_req !== '0 || dout !== '0) begin
            failures++;
            $display("FAIL midreset got=vld %b ack %b dout %h exp=vld 0 ack 000 dout 0",
                     vld_out, ack_req, dout);
        end
        for (int i = 0; i < N; i++) rem[i] = 0;
        drive_inputs();
        model_reset();
        @(posedge clk_user);
        #1 reset = 1'b1;
        for (int i = 0; i < N; i++) rem[i] = 6;
        clear_q();
        t0 = cyc;
        repeat (6) tick();
        checks++;
        if (wq_src.size() == 0 || wq_src[0] != 0 || wq_cyc[0] != t0 + 2) begin
            failures++;
            $display("FAIL midreset_restart got=%0d words first src%0d exp=src0 at cyc%0d",
                     wq_src.size(), wq_src.size() ? wq_src[0] : -1, t0 + 2);
        end
    endtask

    task automatic test_random();
        hold_reset();
        seq_mode = 0;
        for (int i = 0; i < N; i++) nxt[i] = $urandom;
        for (int c = 0; c < 1500; c++) begin
            ack_in = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 7) == 0) rem[i] = $urandom_range(1, 9);
            end
            tick();
        end
`ifdef ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            checks++;
            if (stat_words[i*16 +: 16] !== 16'(m_cnt[i])) begin
                failures++;
                $display("FAIL stat_rand%0d got=%0d exp=%0d", i, stat_words[i*16 +: 16], m_cnt[i]);
            end
        end
`endif
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        int n = 0;
        bit mid_done = 0;
        s_ack_in = 1'b1;
        s_vld    = 2'b10;
        for (int c = 0; c < 72000 && n < 70000; c++) begin
            @(negedge clk_user);
            if (n == 1000 && !mid_done) begin
                mid_done = 1;
                checks++;
                if (s_stat[31:16] !== 16'd1000) begin
                    failures++; $display("FAIL stat_mid got=%0d exp=1000", s_stat[31:16]);
                end
            end
            if (s_ack_req[1]) n++;
        end
        @(posedge clk_user);
        #1 s_vld = 2'b00;
        checks++;
        if (n != 70000) begin
            failures++; $display("FAIL stat_budget got=%0d words exp=70000", n);
        end
        checks++;
        if (s_stat[31:16] !== 16'hFFFF) begin
            failures++; $display("FAIL stat_sat got=%h exp=ffff", s_stat[31:16]);
        end
        checks++;
        if (s_stat[15:0] !== 16'h0000) begin
            failures++; $display("FAIL stat_other got=%h exp=0000", s_stat[15:0]);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; nxt[i] = '0;
        end
        seq_mode = 1;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_random();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
